dlf_pi_sat: RTL and testbench

Parametrised proportional-integral digital loop filter for the bang-bang PLL. It consumes 1-bit PFD decisions, optionally decimated over a programmable window, and updates a saturating integrator scaled by Ki. It emits a registered DCO control word: integrator plus a Kp-scaled proportional term. It sits between the PFD and the DCO tuning input, and adds hold, preload, decimation and saturation flagging.

---
 rtl/dlf_pi_sat.sv | 98 +++++++++
 tb/tb_dlf_pi_sat.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/dlf_pi_sat.sv
// Proportional-integral loop filter for a bang-bang PLL: decimates 1-bit PFD
// decisions into a window sum and drives a saturating DCO control word.
module dlf_pi_sat #(
    parameter int               OUT_W  = 16,
    parameter int               GAIN_W = 8,
    parameter int               DEC_W  = 4,
    parameter logic [OUT_W-1:0] INIT   = 'h4000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic              in,
    input  logic [GAIN_W-1:0] Kp,
    input  logic [GAIN_W-1:0] Ki,
    input  logic [DEC_W-1:0]  dec,
    input  logic              hold,
    input  logic              load,
    input  logic [OUT_W-1:0]  load_val,
    output logic [OUT_W-1:0]  out,
    output logic              out_valid,
    output logic              sat
);
    // Wide enough that mem + gain*window_sum can never overflow before clamping
    localparam int AW = OUT_W + GAIN_W + DEC_W + 3;
    localparam int SW = DEC_W + 2;

    logic        [OUT_W-1:0] mem;
    logic signed [SW-1:0]    s, d, s_nxt;
    logic        [DEC_W-1:0] cnt;
    logic signed [AW-1:0]    s_x, ki_x, kp_x, mem_x, i_full, i_cl_x, p_full;
    logic        [OUT_W-1:0] i_cl, p_cl;
    logic                    i_sat, p_sat, win_done;

    always_comb begin
        d        = in ? {{(SW-1){1'b0}}, 1'b1} : {SW{1'b1}};
        s_nxt    = s + d;
        s_x      = {{(AW-SW){s_nxt[SW-1]}}, s_nxt};
        ki_x     = {{(AW-GAIN_W){1'b0}}, Ki};
        kp_x     = {{(AW-GAIN_W){1'b0}}, Kp};
        mem_x    = {{(AW-OUT_W){1'b0}}, mem};
        win_done = (cnt >= dec);

        i_full = mem_x + ki_x * s_x;
        i_sat  = 1'b1;
        if (i_full[AW-1])
            i_cl = '0;
        else if (|i_full[AW-2:OUT_W])
            i_cl = '1;
        else begin
            i_cl  = i_full[OUT_W-1:0];
            i_sat = 1'b0;
        end

        // Proportional term rides on the clamped integrator but is never stored
        i_cl_x = {{(AW-OUT_W){1'b0}}, i_cl};
        p_full = i_cl_x + kp_x * s_x;
        p_sat  = 1'b1;
        if (p_full[AW-1])
            p_cl = '0;
        else if (|p_full[AW-2:OUT_W])
            p_cl = '1;
        else begin
            p_cl  = p_full[OUT_W-1:0];
            p_sat = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem       <= INIT;
            out       <= INIT;
            s         <= '0;
            cnt       <= '0;
            out_valid <= 1'b0;
            sat       <= 1'b0;
        end else if (load) begin
            mem       <= load_val;
            out       <= load_val;
            s         <= '0;
            cnt       <= '0;
            out_valid <= 1'b0;
            sat       <= 1'b0;
        end else if (hold || !in_valid) begin
            out_valid <= 1'b0;
        end else if (win_done) begin
            mem       <= i_cl;
            out       <= p_cl;
            out_valid <= 1'b1;
            sat       <= i_sat | p_sat;
            s         <= '0;
            cnt       <= '0;
        end else begin
            s         <= s_nxt;
            cnt       <= cnt + DEC_W'(1);
            out_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_dlf_pi_sat.sv
// Directed bench for dlf_pi_sat: one task per scenario, hand-computed expectations.
module tb_dlf_pi_sat;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in = 1'b0;
    logic [7:0]  Kp = '0;
    logic [7:0]  Ki = '0;
    logic [3:0]  dec = '0;
    logic        hold = 1'b0;
    logic        load = 1'b0;
    logic [15:0] load_val = '0;
    logic [15:0] out;
    logic        out_valid;
    logic        sat;

    int tests = 0;
    int fails = 0;

    dlf_pi_sat dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in(in), .Kp(Kp), .Ki(Ki),
        .dec(dec), .hold(hold), .load(load), .load_val(load_val),
        .out(out), .out_valid(out_valid), .sat(sat)
    );

    always #5 clk = ~clk;

    // One clock with the given sample; returns 1 time unit after the edge
    task automatic smp(input logic v, input logic b);
        in_valid = v;
        in       = b;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic do_load(input logic [15:0] val);
        load     = 1'b1;
        load_val = val;
        @(posedge clk);
        #1;
        load = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        tests++; if (out !== 16'h4000) begin fails++; $display("FAIL reset_out got %h exp 4000", out); end
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_ov got %b exp 0", out_valid); end
        tests++; if (sat !== 1'b0) begin fails++; $display("FAIL reset_sat got %b exp 0", sat); end
        // mid-window asynchronous reset restarts the window
        Ki = 8'd1; Kp = 8'd0; dec = 4'd3;
        do_load(16'h1234);
        smp(1, 1); smp(1, 1);
        rst_n = 1'b0;
        #1;
        tests++; if (out !== 16'h4000) begin fails++; $display("FAIL async_reset_out got %h exp 4000", out); end
        #1;
        rst_n = 1'b1;
        smp(1, 1); smp(1, 1); smp(1, 1);
        tests++; if (out_valid !== 1'b0 || out !== 16'h4000) begin fails++; $display("FAIL reset_window_restart got ov=%b out=%h exp ov=0 out=4000", out_valid, out); end
        smp(1, 1);
        tests++; if (out_valid !== 1'b1 || out !== 16'h4004) begin fails++; $display("FAIL reset_window_close got ov=%b out=%h exp ov=1 out=4004", out_valid, out); end
    endtask

    task automatic test_dec0;
        logic [15:0] exp_v [3] = '{16'h4001, 16'h4002, 16'h4003};
        do_load(16'h4000);
        dec = 4'd0; Ki = 8'd1; Kp = 8'd0;
        for (int i = 0; i < 3; i++) begin
            smp(1, 1);
            tests++; if (out !== exp_v[i] || out_valid !== 1'b1) begin fails++; $display("FAIL dec0_up[%0d] got out=%h ov=%b exp out=%h ov=1", i, out, out_valid, exp_v[i]); end
        end
        smp(0, 1);
        tests++; if (out !== 16'h4003 || out_valid !== 1'b0) begin fails++; $display("FAIL dec0_idle got out=%h ov=%b exp out=4003 ov=0", out, out_valid); end
        smp(1, 0);
        tests++; if (out !== 16'h4002 || out_valid !== 1'b1) begin fails++; $display("FAIL dec0_down got out=%h ov=%b exp out=4002 ov=1", out, out_valid); end
    endtask

    task automatic test_pi_window;
        int pulses;
        do_load(16'h4000);
        dec = 4'd3; Ki = 8'd2; Kp = 8'd5;
        pulses = 0;
        smp(1, 1); pulses += out_valid;
        smp(1, 1); pulses += out_valid;
        smp(1, 1); pulses += out_valid;
        tests++; if (pulses != 0) begin fails++; $display("FAIL pi_early_pulse got %0d exp 0", pulses); end
        smp(1, 0);
        tests++; if (out !== 16'h400E || out_valid !== 1'b1) begin fails++; $display("FAIL pi_window got out=%h ov=%b exp out=400e ov=1", out, out_valid); end
        smp(0, 0);
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL pi_ov_pulse got %b exp 0", out_valid); end
        // mem = 4004 (P not accumulated); s' = -4 -> I = 3FFC, P = 3FFC - 20 = 3FE8
        repeat (4) smp(1, 0);
        tests++; if (out !== 16'h3FE8) begin fails++; $display("FAIL pi_no_p_accum got %h exp 3fe8", out); end
    endtask

    task automatic test_sat;
        do_load(16'hFFFE);
        dec = 4'd0; Ki = 8'd4; Kp = 8'd0;
        smp(1, 1);
        tests++; if (out !== 16'hFFFF || sat !== 1'b1) begin fails++; $display("FAIL sat_hi got out=%h sat=%b exp out=ffff sat=1", out, sat); end
        smp(1, 0);
        tests++; if (out !== 16'hFFFB || sat !== 1'b0) begin fails++; $display("FAIL sat_hi_release got out=%h sat=%b exp out=fffb sat=0", out, sat); end
        do_load(16'h0002);
        Ki = 8'd8;
        smp(1, 0);
        tests++; if (out !== 16'h0000 || sat !== 1'b1) begin fails++; $display("FAIL sat_lo got out=%h sat=%b exp out=0000 sat=1", out, sat); end
        // proportional-only clamp leaves the integrator untouched
        do_load(16'hFFF0);
        Ki = 8'd0; Kp = 8'd255;
        smp(1, 1);
        tests++; if (out !== 16'hFFFF || sat !== 1'b1) begin fails++; $display("FAIL sat_p got out=%h sat=%b exp out=ffff sat=1", out, sat); end
        Kp = 8'd0;
        smp(1, 0);
        tests++; if (out !== 16'hFFF0 || sat !== 1'b0) begin fails++; $display("FAIL zero_gain got out=%h sat=%b exp out=fff0 sat=0", out, sat); end
        tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL zero_gain_ov got %b exp 1", out_valid); end
    endtask

    task automatic test_hold;
        int pulses;
        do_load(16'h4000);
        dec = 4'd3; Ki = 8'd1; Kp = 8'd0;
        pulses = 0;
        smp(1, 1); pulses += out_valid;
        smp(1, 1); pulses += out_valid;
        hold = 1'b1;
        for (int i = 0; i < 5; i++) begin
            smp(1, 0); pulses += out_valid;
        end
        hold = 1'b0;
        tests++; if (out !== 16'h4000 || pulses != 0) begin fails++; $display("FAIL hold_freeze got out=%h pulses=%0d exp out=4000 pulses=0", out, pulses); end
        smp(1, 1); pulses += out_valid;
        smp(1, 1); pulses += out_valid;
        tests++; if (out !== 16'h4004 || pulses != 1) begin fails++; $display("FAIL hold_resume got out=%h pulses=%0d exp out=4004 pulses=1", out, pulses); end
    endtask

    task automatic test_load;
        int pulses;
        do_load(16'h4000);
        dec = 4'd3; Ki = 8'd1; Kp = 8'd0;
        smp(1, 1); smp(1, 1);
        do_load(16'h1234);
        tests++; if (out !== 16'h1234 || out_valid !== 1'b0 || sat !== 1'b0) begin fails++; $display("FAIL load_val got out=%h ov=%b sat=%b exp out=1234 ov=0 sat=0", out, out_valid, sat); end
        pulses = 0;
        for (int i = 0; i < 3; i++) begin
            smp(1, 1); pulses += out_valid;
        end
        tests++; if (pulses != 0) begin fails++; $display("FAIL load_restart got pulses=%0d exp 0", pulses); end
        smp(1, 1);
        tests++; if (out !== 16'h1238 || out_valid !== 1'b1) begin fails++; $display("FAIL load_window got out=%h ov=%b exp out=1238 ov=1", out, out_valid); end
    endtask

    task automatic test_dec_change;
        do_load(16'h4000);
        dec = 4'd3; Ki = 8'd1; Kp = 8'd0;
        smp(1, 1); smp(1, 1);
        dec = 4'd0;
        smp(1, 1);
        tests++; if (out !== 16'h4003 || out_valid !== 1'b1) begin fails++; $display("FAIL dec_lowered got out=%h ov=%b exp out=4003 ov=1", out, out_valid); end
        // maximum window: 16 samples
        dec = 4'd15;
        for (int i = 0; i < 15; i++) smp(1, 1);
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL dec_max_early got ov=%b exp 0", out_valid); end
        smp(1, 1);
        tests++; if (out !== 16'h4013 || out_valid !== 1'b1) begin fails++; $display("FAIL dec_max got out=%h ov=%b exp out=4013 ov=1", out, out_valid); end
    endtask

    initial begin
        test_reset();
        test_dec0();
        test_pi_window();
        test_sat();
        test_hold();
        test_load();
        test_dec_change();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
